// File: rtl/m_serial_sub_if.sv
// Start/done handshake and operand/result bundle for the bit-serial subtractor.
// w_ovf exists only when SERIAL_SUB_OVF_EN is defined.
interface m_serial_sub_if #(
    parameter int WIDTH = 8
);
    logic             w_start;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic             w_ready;
    logic             w_busy;
    logic             w_done;
    logic [WIDTH-1:0] w_d;
    logic             w_bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             w_ovf;

    modport master (
        output w_start, w_a, w_b,
        input  w_ready, w_busy, w_done, w_d, w_bout, w_ovf
    );

    modport slave (
        input  w_start, w_a, w_b,
        output w_ready, w_busy, w_done, w_d, w_bout, w_ovf
    );
`else
    modport master (
        output w_start, w_a, w_b,
        input  w_ready, w_busy, w_done, w_d, w_bout
    );

    modport slave (
        input  w_start, w_a, w_b,
        output w_ready, w_busy, w_done, w_d, w_bout
    );
`endif
endinterface

// File: rtl/m_serial_sub.sv
// Bit-serial subtractor D = A - B, LSB first, one full-subtractor step per clock.
// Optional SERIAL_SUB_OVF_EN adds a registered two's-complement overflow flag.
module m_serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic          w_clk,
    input  logic          w_rst,
    m_serial_sub_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Returns {borrow_out, difference} of one full-subtractor cell.
    function automatic logic [1:0] full_sub_cell(input logic a_bit, input logic b_bit,
                                                 input logic br_in);
        logic diff;
        logic bor;
        diff = a_bit ^ b_bit ^ br_in;
        bor  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_in);
        return {bor, diff};
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic             accept_s;
    logic             last_s;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic             br_r;
    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       cell_s;
    logic             d_bit_s;
    logic             br_nxt_s;
    logic [WIDTH-1:0] res_nxt_s;
    logic             ready_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] d_r;
    logic             bout_r;

    // Next-state decode and accept/last-bit strobes.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        last_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.w_start) begin
                    state_nxt_s = ST_RUN;
                    accept_s    = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_r == LAST_BIT) begin
                    state_nxt_s = ST_DONE;
                    last_s      = 1'b1;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Full-subtractor cell on the current LSBs; the minuend register doubles as
    // the result register, its vacated MSB receiving each difference bit.
    always_comb begin
        cell_s    = full_sub_cell(a_sh_r[0], b_sh_r[0], br_r);
        d_bit_s   = cell_s[0];
        br_nxt_s  = cell_s[1];
        res_nxt_s = {d_bit_s, a_sh_r[WIDTH-1:1]};
    end

    // FSM state register.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Handshake flags registered from the next state so they track state exactly.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            ready_r <= (state_nxt_s == ST_IDLE);
            busy_r  <= (state_nxt_s == ST_RUN);
            done_r  <= (state_nxt_s == ST_DONE);
        end
    end

    // Operand shift registers, running borrow and bit counter.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            a_sh_r <= {WIDTH{1'b0}};
            b_sh_r <= {WIDTH{1'b0}};
            br_r   <= 1'b0;
            cnt_r  <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            a_sh_r <= bus.w_a;
            b_sh_r <= bus.w_b;
            br_r   <= 1'b0;
            cnt_r  <= {CNT_W{1'b0}};
        end else if (state_r == ST_RUN) begin
            a_sh_r <= res_nxt_s;
            b_sh_r <= {1'b0, b_sh_r[WIDTH-1:1]};
            br_r   <= br_nxt_s;
            cnt_r  <= cnt_r + CNT_ONE;
        end
    end

    // Result and final borrow, loaded only on the last bit and held afterwards.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            d_r    <= {WIDTH{1'b0}};
            bout_r <= 1'b0;
        end else if (last_s) begin
            d_r    <= res_nxt_s;
            bout_r <= br_nxt_s;
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic ovf_r;

    // On the last bit the operand LSBs hold the original sign bits.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            ovf_r <= 1'b0;
        end else if (last_s) begin
            ovf_r <= (a_sh_r[0] ^ b_sh_r[0]) & (a_sh_r[0] ^ d_bit_s);
        end
    end

    assign bus.w_ovf = ovf_r;
`endif

    assign bus.w_ready = ready_r;
    assign bus.w_busy  = busy_r;
    assign bus.w_done  = done_r;
    assign bus.w_d     = d_r;
    assign bus.w_bout  = bout_r;
endmodule

// File: tb/tb_m_serial_sub.sv
// Self-checking bench for m_serial_sub: 8-bit directed table plus corner sequences,
// and an exhaustive 4-bit sweep. Overflow checks are active under SERIAL_SUB_OVF_EN.
module tb_m_serial_sub;
    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic       bout;
        logic       ovf;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       bout;
        logic       ovf;
    } exp8_t;

    typedef struct {
        logic [3:0] d;
        logic       bout;
    } exp4_t;

    logic w_clk = 1'b0;
    logic w_rst;
    int   n_vec = 0;
    int   n_err = 0;

    exp8_t sb8[$];
    exp4_t sb4[$];
    exp8_t cur8;
    exp4_t cur4;
    vec_t  vecs[9];

    m_serial_sub_if #(.WIDTH(8)) bus8 ();
    m_serial_sub_if #(.WIDTH(4)) bus4 ();

    m_serial_sub #(.WIDTH(8)) dut8 (.w_clk(w_clk), .w_rst(w_rst), .bus(bus8));
    m_serial_sub #(.WIDTH(4)) dut4 (.w_clk(w_clk), .w_rst(w_rst), .bus(bus4));

    always #5 w_clk = ~w_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard consumers: each done pulse pops and compares one expectation.
    always @(negedge w_clk) begin
        if (bus8.w_done === 1'b1) begin
            check("done8_expected", 32'(sb8.size() != 0), 32'd1);
            if (sb8.size() != 0) begin
                cur8 = sb8.pop_front();
                check("d8", 32'(bus8.w_d), 32'(cur8.d));
                check("bout8", 32'(bus8.w_bout), 32'(cur8.bout));
`ifdef SERIAL_SUB_OVF_EN
                check("ovf8", 32'(bus8.w_ovf), 32'(cur8.ovf));
`endif
            end
        end
        if (bus4.w_done === 1'b1) begin
            check("done4_expected", 32'(sb4.size() != 0), 32'd1);
            if (sb4.size() != 0) begin
                cur4 = sb4.pop_front();
                check("d4", 32'(bus4.w_d), 32'(cur4.d));
                check("bout4", 32'(bus4.w_bout), 32'(cur4.bout));
            end
        end
    end

    task automatic wait_ready8();
        int t = 0;
        while (bus8.w_ready !== 1'b1 && t < 40) begin
            @(negedge w_clk);
            t++;
        end
        check("ready8_wait", 32'(bus8.w_ready), 32'd1);
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input exp8_t e);
        int t = 0;
        wait_ready8();
        bus8.w_start = 1'b1;
        bus8.w_a     = a;
        bus8.w_b     = b;
        sb8.push_back(e);
        @(negedge w_clk);
        bus8.w_start = 1'b0;
        while (sb8.size() != 0 && t < 40) begin
            @(negedge w_clk);
            t++;
        end
        check("drain8", 32'(sb8.size()), 32'd0);
        sb8.delete();
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b);
        int    t = 0;
        exp4_t e;
        while (bus4.w_ready !== 1'b1 && t < 40) begin
            @(negedge w_clk);
            t++;
        end
        e.d    = a - b;
        e.bout = (a < b);
        bus4.w_start = 1'b1;
        bus4.w_a     = a;
        bus4.w_b     = b;
        sb4.push_back(e);
        @(negedge w_clk);
        bus4.w_start = 1'b0;
        t = 0;
        while (sb4.size() != 0 && t < 40) begin
            @(negedge w_clk);
            t++;
        end
        check("drain4", 32'(sb4.size()), 32'd0);
        sb4.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int    busy_cnt;
        int    done_at;
        int    done_cnt;
        int    last_done;
        exp8_t e;

        vecs[0] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
        vecs[1] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
        vecs[3] = '{8'h7F, 8'h01, 8'h7E, 1'b0, 1'b0};
        vecs[4] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
        vecs[5] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
        vecs[6] = '{8'h5A, 8'h00, 8'h5A, 1'b0, 1'b0};
        vecs[7] = '{8'hAA, 8'h55, 8'h55, 1'b0, 1'b1};
        vecs[8] = '{8'h01, 8'h80, 8'h81, 1'b1, 1'b1};

        w_rst        = 1'b1;
        bus8.w_start = 1'b0;
        bus8.w_a     = 8'h00;
        bus8.w_b     = 8'h00;
        bus4.w_start = 1'b0;
        bus4.w_a     = 4'h0;
        bus4.w_b     = 4'h0;
        repeat (2) @(negedge w_clk);
        check("rst_ready", 32'(bus8.w_ready), 32'd1);
        check("rst_busy", 32'(bus8.w_busy), 32'd0);
        check("rst_done", 32'(bus8.w_done), 32'd0);
        check("rst_d", 32'(bus8.w_d), 32'd0);
        check("rst_bout", 32'(bus8.w_bout), 32'd0);
        w_rst = 1'b0;
        @(negedge w_clk);

        // 5 - 3: latency, busy length and result hold.
        e = '{8'h02, 1'b0, 1'b0};
        sb8.push_back(e);
        bus8.w_start = 1'b1;
        bus8.w_a     = 8'h05;
        bus8.w_b     = 8'h03;
        @(negedge w_clk);
        bus8.w_start = 1'b0;
        busy_cnt = 0;
        done_at  = 0;
        for (int c = 1; c <= 12; c++) begin
            if (bus8.w_busy === 1'b1) busy_cnt++;
            if (bus8.w_done === 1'b1 && done_at == 0) done_at = c;
            @(negedge w_clk);
        end
        check("busy_cycles", 32'(busy_cnt), 32'd8);
        check("done_cycle", 32'(done_at), 32'd9);
        for (int c = 0; c < 5; c++) begin
            check("hold_d", 32'(bus8.w_d), 32'h02);
            check("hold_bout", 32'(bus8.w_bout), 32'd0);
            @(negedge w_clk);
        end

        for (int i = 0; i < 9; i++) begin
            e = '{vecs[i].d, vecs[i].bout, vecs[i].ovf};
            run8(vecs[i].a, vecs[i].b, e);
        end

        // Start held high; operands scrambled whenever the unit is busy.
        wait_ready8();
        bus8.w_start = 1'b1;
        done_cnt  = 0;
        last_done = -1;
        for (int n = 0; n <= 30; n++) begin
            if (bus8.w_done === 1'b1) begin
                done_cnt++;
                if (last_done >= 0) check("b2b_interval", 32'(n - last_done), 32'd10);
                last_done = n;
            end
            if (bus8.w_busy === 1'b1) begin
                bus8.w_a = 8'($urandom());
                bus8.w_b = 8'($urandom());
            end else begin
                bus8.w_a = 8'h10;
                bus8.w_b = 8'h01;
            end
            if (bus8.w_ready === 1'b1) begin
                e = '{8'h0F, 1'b0, 1'b0};
                sb8.push_back(e);
            end
            @(negedge w_clk);
        end
        bus8.w_start = 1'b0;
        check("b2b_done_count", 32'(done_cnt), 32'd3);
        for (int t = 0; t < 40 && sb8.size() != 0; t++) @(negedge w_clk);
        check("b2b_drain", 32'(sb8.size()), 32'd0);
        sb8.delete();

        // Reset in the 4th RUN cycle aborts with no done pulse.
        wait_ready8();
        bus8.w_start = 1'b1;
        bus8.w_a     = 8'hAA;
        bus8.w_b     = 8'h55;
        @(negedge w_clk);
        bus8.w_start = 1'b0;
        repeat (3) @(negedge w_clk);
        check("abort_busy_before", 32'(bus8.w_busy), 32'd1);
        w_rst = 1'b1;
        @(negedge w_clk);
        w_rst = 1'b0;
        check("abort_ready", 32'(bus8.w_ready), 32'd1);
        check("abort_busy", 32'(bus8.w_busy), 32'd0);
        check("abort_done", 32'(bus8.w_done), 32'd0);
        check("abort_d", 32'(bus8.w_d), 32'd0);
        check("abort_bout", 32'(bus8.w_bout), 32'd0);
        done_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            if (bus8.w_done === 1'b1) done_cnt++;
            @(negedge w_clk);
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);
        e = '{8'h55, 1'b0, 1'b1};
        run8(8'hAA, 8'h55, e);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run4(4'(a), 4'(b));
            end
        end

        repeat (2) @(negedge w_clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
